// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: reset polarity constants,
// sequencer state encoding and reset-cause codes.
package rst_seq_pkg;

    // Active-low domain reset levels.
    localparam logic RESET_ENABLE  = 1'b0;
    localparam logic RESET_DISABLE = 1'b1;

    // Sequencer states, in release order.
    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_REL_MEM   = 3'd2,
        ST_REL_IO    = 3'd3,
        ST_REL_CPU   = 3'd4,
        ST_RUN       = 3'd5
    } state_t;

    // Reason for the most recent reset sequence.
    typedef enum logic [1:0] {
        CAUSE_POR  = 2'd0,
        CAUSE_LOCK = 2'd1,
        CAUSE_SW   = 2'd2,
        CAUSE_WDT  = 2'd3
    } cause_t;

endpackage

// File: rtl/rst_seq_sync_ff.sv
// Multi-stage flip-flop synchronizer with asynchronous active-low clear.
// Used both for the reset_ release edge and for the asynchronous DCM lock.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic arst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the input through STAGES flops; cleared while arst_n is low.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: holds mem/io/cpu domain resets while the chip reset or
// DCM lock is bad, then releases them one at a time (mem, io, cpu) spaced
// STAGE_DLY cycles apart. Lock loss, a software request or a watchdog
// timeout re-asserts all three together and restarts the release sequence.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int STAGE_DLY   = 16,
    parameter int WDT_LIMIT   = 65535
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       locked,
    input  logic       sw_rst_req,
    input  logic       wdt_kick,
    output logic       mem_reset_,
    output logic       io_reset_,
    output logic       cpu_reset_,
    output logic [1:0] rst_cause,
    output logic       seq_busy
);

    localparam logic [7:0]  STAGE_DLY_C = 8'(STAGE_DLY);
    localparam logic [15:0] WDT_LIMIT_C = 16'(WDT_LIMIT);
    localparam bit          WDT_EN      = (WDT_LIMIT != 0);

    logic   rst_sync;
    logic   lock_sync;

    state_t      state_q;
    cause_t      cause_q;
    logic [7:0]  stage_cnt_q;
    logic [15:0] wdt_q;
    logic        mem_rst_q;
    logic        io_rst_q;
    logic        cpu_rst_q;
    logic        busy_q;

    logic   lock_lost;
    logic   wdt_expire;
    logic   sw_req_run;
    logic   abort;
    cause_t abort_cause;

    // reset_ release edge: constant 1 shifted in once reset_ goes high.
    sync_ff #(.STAGES(SYNC_STAGES)) u_rst_sync (
        .clk    (clk),
        .arst_n (reset_),
        .d_i    (1'b1),
        .q_o    (rst_sync)
    );

    // DCM lock status, asynchronous to clk.
    sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk    (clk),
        .arst_n (reset_),
        .d_i    (locked),
        .q_o    (lock_sync)
    );

    // Re-sequence triggers. WAIT_LOCK is already waiting for lock, so a low
    // lock there is not a new event and leaves rst_cause alone (this keeps a
    // slow-locking DCM at power-up reported as a power/pin reset).
    always_comb begin
        lock_lost   = !lock_sync &&
                      (state_q inside {ST_REL_MEM, ST_REL_IO, ST_REL_CPU, ST_RUN});
        // Expire on the cycle the count would reach the limit, so the resets
        // drop exactly WDT_LIMIT cycles after RUN entry or the last kick.
        wdt_expire  = WDT_EN && (state_q == ST_RUN) && !wdt_kick &&
                      (wdt_q == WDT_LIMIT_C - 16'd1);
        sw_req_run  = (state_q == ST_RUN) && sw_rst_req;
        abort       = lock_lost || wdt_expire || sw_req_run;
        abort_cause = lock_lost  ? CAUSE_LOCK :
                      wdt_expire ? CAUSE_WDT  : CAUSE_SW;
    end

    // Sequencer FSM with registered domain resets, busy flag and cause.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q     <= ST_HOLD;
            cause_q     <= CAUSE_POR;
            stage_cnt_q <= '0;
            wdt_q       <= '0;
            mem_rst_q   <= RESET_ENABLE;
            io_rst_q    <= RESET_ENABLE;
            cpu_rst_q   <= RESET_ENABLE;
            busy_q      <= 1'b1;
        end else if (abort) begin
            state_q     <= ST_WAIT_LOCK;
            cause_q     <= abort_cause;
            stage_cnt_q <= '0;
            wdt_q       <= '0;
            mem_rst_q   <= RESET_ENABLE;
            io_rst_q    <= RESET_ENABLE;
            cpu_rst_q   <= RESET_ENABLE;
            busy_q      <= 1'b1;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (rst_sync) begin
                        state_q <= ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_sync) begin
                        state_q     <= ST_REL_MEM;
                        stage_cnt_q <= STAGE_DLY_C;
                        mem_rst_q   <= RESET_DISABLE;
                    end
                end
                // Counter steps to 0 over STAGE_DLY cycles; leaving on the
                // step that lands on 0 spaces releases exactly STAGE_DLY apart.
                ST_REL_MEM: begin
                    if (stage_cnt_q <= 8'd1) begin
                        state_q     <= ST_REL_IO;
                        stage_cnt_q <= STAGE_DLY_C;
                        io_rst_q    <= RESET_DISABLE;
                    end else begin
                        stage_cnt_q <= stage_cnt_q - 8'd1;
                    end
                end
                ST_REL_IO: begin
                    if (stage_cnt_q <= 8'd1) begin
                        state_q     <= ST_REL_CPU;
                        stage_cnt_q <= STAGE_DLY_C;
                        cpu_rst_q   <= RESET_DISABLE;
                    end else begin
                        stage_cnt_q <= stage_cnt_q - 8'd1;
                    end
                end
                ST_REL_CPU: begin
                    if (stage_cnt_q <= 8'd1) begin
                        state_q     <= ST_RUN;
                        stage_cnt_q <= '0;
                        busy_q      <= 1'b0;
                    end else begin
                        stage_cnt_q <= stage_cnt_q - 8'd1;
                    end
                end
                ST_RUN: begin
                    // Saturate rather than wrap (matters only when disabled).
                    if (wdt_kick) begin
                        wdt_q <= '0;
                    end else if (wdt_q != 16'hFFFF) begin
                        wdt_q <= wdt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= ST_HOLD;
                end
            endcase
        end
    end

    assign mem_reset_ = mem_rst_q;
    assign io_reset_  = io_rst_q;
    assign cpu_reset_ = cpu_rst_q;
    assign rst_cause  = cause_q;
    assign seq_busy   = busy_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq (SYNC_STAGES=2, STAGE_DLY=16, WDT_LIMIT=100).
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_rst_seq;

    logic       clk;
    logic       reset_;
    logic       locked;
    logic       sw_rst_req;
    logic       wdt_kick;
    logic       mem_reset_;
    logic       io_reset_;
    logic       cpu_reset_;
    logic [1:0] rst_cause;
    logic       seq_busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    rst_seq #(
        .SYNC_STAGES (2),
        .STAGE_DLY   (16),
        .WDT_LIMIT   (100)
    ) dut (
        .clk        (clk),
        .reset_     (reset_),
        .locked     (locked),
        .sw_rst_req (sw_rst_req),
        .wdt_kick   (wdt_kick),
        .mem_reset_ (mem_reset_),
        .io_reset_  (io_reset_),
        .cpu_reset_ (cpu_reset_),
        .rst_cause  (rst_cause),
        .seq_busy   (seq_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 ns.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
            $display("t=%0t %s: got %0h want %0h ok", $time, tag, obs, exp);
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full release from entry into REL_MEM: io +16, cpu +16, RUN +16.
    task automatic release_rest(input string ph);
        tick(16); chk({ph, " io released"}, io_reset_, 1);
        tick(16); chk({ph, " cpu released"}, cpu_reset_, 1);
        tick(15); chk({ph, " busy before run"}, seq_busy, 1);
        tick(1);  chk({ph, " busy at run"}, seq_busy, 0);
    endtask

    initial begin
        reset_ = 1'b0; locked = 1'b1; sw_rst_req = 1'b0; wdt_kick = 1'b0;

        // Power-on reset held 5 cycles.
        tick(5);
        chk("por mem", mem_reset_, 0);
        chk("por io", io_reset_, 0);
        chk("por cpu", cpu_reset_, 0);
        chk("por busy", seq_busy, 1);
        chk("por cause", rst_cause, 0);

        // Release: mem at edge 4 (2 sync + HOLD + WAIT_LOCK), then 16 apart.
        reset_ = 1'b1;
        tick(3); chk("pwr mem before", mem_reset_, 0);
        tick(1); chk("pwr mem at 4", mem_reset_, 1);
        chk("pwr io still low", io_reset_, 0);
        tick(15); chk("pwr io before", io_reset_, 0);
        tick(1);  chk("pwr io at +16", io_reset_, 1);
        chk("pwr cpu still low", cpu_reset_, 0);
        tick(15); chk("pwr cpu before", cpu_reset_, 0);
        tick(1);  chk("pwr cpu at +16", cpu_reset_, 1);
        tick(15); chk("pwr busy before", seq_busy, 1);
        tick(1);  chk("pwr busy at +16", seq_busy, 0);
        chk("pwr cause", rst_cause, 0);

        // Kick every 50 cycles for 1000 cycles: no watchdog reset.
        for (int i = 0; i < 20; i++) begin
            tick(49);
            wdt_kick = 1'b1;
            tick(1);
            wdt_kick = 1'b0;
            chk("kick cpu alive", cpu_reset_, 1);
        end
        chk("kick busy", seq_busy, 0);

        // Software reset from RUN: all resets low on the next edge.
        sw_rst_req = 1'b1; tick(1); sw_rst_req = 1'b0;
        chk("sw mem", mem_reset_, 0);
        chk("sw io", io_reset_, 0);
        chk("sw cpu", cpu_reset_, 0);
        chk("sw busy", seq_busy, 1);
        chk("sw cause", rst_cause, 2);
        tick(1); chk("sw mem released", mem_reset_, 1);
        tick(16); chk("sw io released", io_reset_, 1);
        // Software request in REL_IO is ignored.
        sw_rst_req = 1'b1; tick(1); sw_rst_req = 1'b0;
        chk("sw in rel_io mem", mem_reset_, 1);
        chk("sw in rel_io io", io_reset_, 1);
        tick(15); chk("sw cpu released", cpu_reset_, 1);
        tick(16); chk("sw run busy", seq_busy, 0);

        // Lock loss for 10 cycles: resets low after SYNC_STAGES+1 edges.
        locked = 1'b0;
        tick(2); chk("lock cpu before", cpu_reset_, 1);
        tick(1); chk("lock cpu low", cpu_reset_, 0);
        chk("lock mem low", mem_reset_, 0);
        chk("lock cause", rst_cause, 1);
        tick(7); locked = 1'b1;
        tick(2); chk("relock mem before", mem_reset_, 0);
        tick(1); chk("relock mem", mem_reset_, 1);
        release_rest("relock");
        chk("relock cause", rst_cause, 1);

        // Watchdog, no kicks: reset exactly 100 cycles into RUN.
        tick(99); chk("wdt cpu at 99", cpu_reset_, 1);
        tick(1);  chk("wdt cpu at 100", cpu_reset_, 0);
        chk("wdt cause", rst_cause, 3);
        tick(1); chk("wdt mem released", mem_reset_, 1);
        release_rest("wdt");

        // Watchdog expiry and software request together: watchdog wins.
        tick(99);
        sw_rst_req = 1'b1; tick(1); sw_rst_req = 1'b0;
        chk("both cpu low", cpu_reset_, 0);
        chk("both cause", rst_cause, 3);

        // reset_ pulse mid REL_IO: immediate reset, cause back to 0.
        tick(1); chk("pin mem released", mem_reset_, 1);
        tick(16); chk("pin io released", io_reset_, 1);
        tick(5);
        reset_ = 1'b0; #1;
        chk("pin async mem", mem_reset_, 0);
        chk("pin async io", io_reset_, 0);
        chk("pin busy", seq_busy, 1);
        chk("pin cause", rst_cause, 0);
        tick(2); reset_ = 1'b1;
        tick(3); chk("pin mem before", mem_reset_, 0);
        tick(1); chk("pin mem at 4", mem_reset_, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
